// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT types and size helpers for the SDF butterfly, twiddle and top-level blocks.
package fft_pkg;
  typedef enum logic {BF_I, BF_II} bf_type_e;
  function automatic int sdf_delay(int n_points, int stage, bf_type_e bt);
    return n_points >> (2 * stage + (bt == BF_II ? 2 : 1));
  endfunction
  function automatic int sdf_iw(int dw);
    return dw + 1;
  endfunction
  function automatic int sdf_ow(int dw, int scale);
    return scale != 0 ? dw : dw + 1;
  endfunction
endpackage

// File: rtl/sdf_bf_stage_if.sv
// sdf_bf_stage_if: complex sample stream with valid and frame-start; master drives, slave receives.
interface sdf_bf_stage_if #(parameter int W = 16);
  logic valid;
  logic sof;
  logic signed [W-1:0] re;
  logic signed [W-1:0] im;
  modport master(output valid, sof, re, im);
  modport slave(input valid, sof, re, im);
endinterface

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: DEPTH-entry circular buffer, read-before-write on a shared pointer.
module sdf_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);
  if (DEPTH == 1) begin : g_reg
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (en) q <= wr_data;
    assign rd_data = q;
  end else begin : g_ram
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        ptr <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (en) begin
        mem[ptr] <= wr_data;
        ptr <= ptr == AW'(DEPTH - 1) ? '0 : ptr + 1'b1;
      end
    assign rd_data = mem[ptr];
  end
endmodule

// File: rtl/sdf_bf_stage.sv
// sdf_bf_stage: radix-2^2 SDF butterfly (BFI/BFII) with phase counter and optional /2 scaling.
// Define SDF_BF_ROUND_EN to round half up when SCALE = 1 (otherwise truncate toward -inf).
module sdf_bf_stage import fft_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16,
  parameter int STAGE      = 0,
  parameter int BF_TYPE    = 0,
  parameter int SCALE      = 0
) (
  input logic clk,
  input logic rst,
  sdf_bf_stage_if.slave  din,
  sdf_bf_stage_if.master dout
);
  localparam bf_type_e BT = bf_type_e'(BF_TYPE);
  localparam int D  = sdf_delay(N_POINTS, STAGE, BT);
  localparam int LD = $clog2(D);
  localparam int CW = LD + (BT == BF_II ? 2 : 1);
  localparam int IW = sdf_iw(DATA_WIDTH);
  localparam int OW = sdf_ow(DATA_WIDTH, SCALE);
`ifdef SDF_BF_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  logic [CW-1:0] cnt, cnt_eff;
  logic p, r, rot, primed, armed, ov, os, at_d;
  logic signed [IW-1:0] xr, xi, fr, fi, yr, yi;
  logic [2*IW-1:0] rd, wd;
  logic signed [OW-1:0] ore, oim, ore_d, oim_d;
  // A frame start forces phase 0 for this very sample
  assign cnt_eff = din.sof ? '0 : cnt;
  assign p       = cnt_eff[LD];
  assign at_d    = cnt_eff == CW'(D);
  if (BT == BF_II) begin : g_rot
    assign r = cnt_eff[LD+1];
  end else begin : g_fwd
    assign r = 1'b0;
  end
  assign rot = p && r;
  always_comb begin
    xr = rot ? IW'(din.im) : IW'(din.re);
    xi = rot ? -IW'(din.re) : IW'(din.im);
    {fr, fi} = rd;
    yr = p ? fr + xr : fr;
    yi = p ? fi + xi : fi;
    wd = p ? {fr - xr, fi - xi} : {xr, xi};
    ore_d = OW'(SCALE != 0 ? (int'(yr) + RND) >>> 1 : int'(yr));
    oim_d = OW'(SCALE != 0 ? (int'(yi) + RND) >>> 1 : int'(yi));
  end
  sdf_delay_line #(.DEPTH(D), .WIDTH(2 * IW)) u_dl (
    .clk(clk), .rst(rst), .en(din.valid), .wr_data(wd), .rd_data(rd)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt    <= '0;
      primed <= 1'b0;
      armed  <= 1'b0;
      ov     <= 1'b0;
      os     <= 1'b0;
      ore    <= '0;
      oim    <= '0;
    end else begin
      ov <= din.valid && (primed || p);
      os <= din.valid && armed && at_d;
      if (din.valid) begin
        cnt    <= cnt_eff + 1'b1;
        primed <= primed || p;
        armed  <= din.sof || (armed && !at_d);
        ore    <= ore_d;
        oim    <= oim_d;
      end
    end
  assign dout.valid = ov;
  assign dout.sof   = os;
  assign dout.re    = ore;
  assign dout.im    = oim;
endmodule

// File: tb/tb_sdf_bf_stage.sv
// tb_sdf_bf_stage: directed checks of BFI, BFII and scaled stages against hand-computed outputs.
module tb_sdf_bf_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  sdf_bf_stage_if #(16) i1(), i2(), i3();
  sdf_bf_stage_if #(17) o1(), o2();
  sdf_bf_stage_if #(16) o3();
  sdf_bf_stage #(.DATA_WIDTH(16), .N_POINTS(16), .STAGE(1), .BF_TYPE(0), .SCALE(0)) u1 (
    .clk(clk), .rst(rst), .din(i1), .dout(o1));
  sdf_bf_stage #(.DATA_WIDTH(16), .N_POINTS(16), .STAGE(1), .BF_TYPE(1), .SCALE(0)) u2 (
    .clk(clk), .rst(rst), .din(i2), .dout(o2));
  sdf_bf_stage #(.DATA_WIDTH(16), .N_POINTS(8), .STAGE(1), .BF_TYPE(0), .SCALE(1)) u3 (
    .clk(clk), .rst(rst), .din(i3), .dout(o3));
`ifdef SDF_BF_ROUND_EN
  localparam int S_P3 = 2, S_M1 = 0, S_M3 = -1;
`else
  localparam int S_P3 = 1, S_M1 = -1, S_M3 = -2;
`endif
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input int sel, input logic s, input int re, input int im);
    i1.valid = sel == 1; i2.valid = sel == 2; i3.valid = sel == 3;
    i1.sof = s; i2.sof = s; i3.sof = s;
    i1.re = 16'(re); i2.re = 16'(re); i3.re = 16'(re);
    i1.im = 16'(im); i2.im = 16'(im); i3.im = 16'(im);
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rst_valid", int'(o1.valid), 0);
    chk("rst_sof", int'(o1.sof), 0);
    chk("rst_re", int'(o1.re), 0);
    chk("rst_im", int'(o2.im), 0);
    rst = 1'b1;
    drive(1, 1, 1, 0); chk("s1_v0", int'(o1.valid), 0);
    drive(1, 0, 2, 0); chk("s1_v1", int'(o1.valid), 0);
    drive(1, 0, 3, 0); chk("s1_v2", int'(o1.valid), 1);
    chk("s1_sof2", int'(o1.sof), 1); chk("s1_re2", int'(o1.re), 4);
    drive(1, 0, 4, 0); chk("s1_re3", int'(o1.re), 6); chk("s1_sof3", int'(o1.sof), 0);
    drive(1, 0, 0, 0); chk("s1_re4", int'(o1.re), -2);
    drive(1, 0, 0, 0); chk("s1_re5", int'(o1.re), -2); chk("s1_v5", int'(o1.valid), 1);
    drive(0, 0, 0, 0); chk("s1_idle_v", int'(o1.valid), 0); chk("s1_idle_re", int'(o1.re), -2);
    drive(2, 1, 1, 0); chk("s2_v0", int'(o2.valid), 0);
    drive(2, 0, 2, 0); chk("s2_v1", int'(o2.valid), 1); chk("s2_sof1", int'(o2.sof), 1);
    chk("s2_re1", int'(o2.re), 3); chk("s2_im1", int'(o2.im), 0);
    drive(2, 0, 5, 0); chk("s2_re2", int'(o2.re), -1); chk("s2_sof2", int'(o2.sof), 0);
    drive(2, 0, 0, 1); chk("s2_re3", int'(o2.re), 6); chk("s2_im3", int'(o2.im), 0);
    drive(3, 1, 1, 0); chk("sc_v0", int'(o3.valid), 0);
    drive(3, 0, 2, 0); chk("sc_p3", int'(o3.re), S_P3); chk("sc_sof", int'(o3.sof), 1);
    drive(3, 0, -1, 0); chk("sc_m1", int'(o3.re), S_M1);
    drive(3, 0, -2, 0); chk("sc_m3", int'(o3.re), S_M3); chk("sc_sof3", int'(o3.sof), 0);
    drive(1, 1, 7, 7);
    drive(1, 0, 8, 8);
    drive(1, 0, 9, 9); chk("pre_rst_re", int'(o1.re), 16); chk("pre_rst_im", int'(o1.im), 16);
    rst = 1'b0;
    #1;
    chk("arst_valid", int'(o1.valid), 0);
    chk("arst_sof", int'(o1.sof), 0);
    chk("arst_re", int'(o1.re), 0);
    chk("arst_im", int'(o1.im), 0);
    chk("arst_re2", int'(o2.re), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, 1, 1, 0); chk("st_v0", int'(o1.valid), 0);
    drive(0, 0, 0, 0); chk("st_b0", int'(o1.valid), 0);
    drive(1, 0, 2, 0); chk("st_v1", int'(o1.valid), 0);
    drive(1, 0, 3, 0); chk("st_re2", int'(o1.re), 4); chk("st_sof2", int'(o1.sof), 1);
    drive(0, 0, 0, 0); chk("st_b1", int'(o1.valid), 0); chk("st_hold", int'(o1.re), 4);
    chk("st_b1_sof", int'(o1.sof), 0);
    drive(1, 0, 4, 0); chk("st_re3", int'(o1.re), 6); chk("st_v3", int'(o1.valid), 1);
    drive(0, 0, 0, 0); chk("st_b2", int'(o1.valid), 0);
    drive(0, 0, 0, 0); chk("st_b3", int'(o1.valid), 0);
    drive(1, 0, 0, 0); chk("st_re4", int'(o1.re), -2);
    drive(1, 0, 0, 0); chk("st_re5", int'(o1.re), -2);
    drive(1, 1, -32768, -32768);
    drive(1, 0, 0, 0);
    drive(1, 0, -32768, -32768);
    chk("ext_re", int'(o1.re), -65536); chk("ext_im", int'(o1.im), -65536);
    drive(2, 1, 0, 0);
    drive(2, 0, 0, 0);
    drive(2, 0, 0, 0);
    drive(2, 0, -32768, 0);
    chk("ext_rot_re", int'(o2.re), 0); chk("ext_rot_im", int'(o2.im), 32768);
    drive(1, 1, 10, 0);
    drive(1, 0, 20, 0);
    drive(1, 1, 30, 0); chk("mid_sof0", int'(o1.sof), 0); chk("mid_fill", int'(o1.re), 10);
    drive(1, 0, 40, 0); chk("mid_sof1", int'(o1.sof), 0);
    drive(1, 0, 50, 0); chk("mid_sof2", int'(o1.sof), 1); chk("mid_re2", int'(o1.re), 80);
    drive(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdf_bf_stage.md
# sdf_bf_stage

Parametrised radix-2² single-path delay-feedback (SDF) butterfly stage for the pipelined FFT. One instance implements either a BFI or a BFII butterfly, selected by parameter, with its own phase counter, valid/frame-start handshake and optional ÷2 scaling. Stages chain output-to-input to form the full FFT datapath; twiddle multipliers sit between BFII and the next BFI.

## Interface
- DATA_WIDTH, 16: input sample width per component, two's complement.
- N_POINTS, 16: FFT length; power of two, ≥ 4.
- STAGE, 0: radix-2² stage index; sets delay depth.
- BF_TYPE, 0: 0 = BFI, 1 = BFII (adds the −j rotation).
- SCALE, 0: 1 = divide every output by 2.
- Derived: D = N_POINTS >> (2·STAGE+1) for BFI, N_POINTS >> (2·STAGE+2) for BFII; D ≥ 1 is required. IW = DATA_WIDTH+1 (internal). OW = SCALE ? DATA_WIDTH : DATA_WIDTH+1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample present; low = stall, all state frozen.
- in_sof  in  1  first sample of a frame; qualified by in_valid.
- in_re, in_im  in  DATA_WIDTH each  input sample.
- out_valid  out  1  output sample valid.
- out_sof  out  1  first output of a frame.
- out_re, out_im  out  OW each  output sample.

## Operation
- Phase counter cnt, width log2(2D) (BFI) or log2(4D) (BFII), advances by 1 per accepted sample, wraps to 0. If in_valid && in_sof, the sample is processed with cnt = 0 and cnt becomes 1.
- Phase bit p = cnt[log2 D]: p = 0 FILL, p = 1 BFLY. BFII rotation bit r = cnt[log2 D + 1].
- Input x = sign-extended (in_re, in_im) at IW. BFII only, when p = 1 and r = 1: x ← −j·x, i.e. (re, im) → (im, −re), computed at IW.
- Delay line: D entries of IW-bit complex values; f = entry read this cycle (written D accepted samples earlier).
- FILL: output f; write x.
- BFLY: output f + x; write f − x.
- Result y: IW bits (no overflow, since inputs are sign-extended). SCALE = 0: output y. SCALE = 1: output y >>> 1 (arithmetic shift right), rounded per Configuration.
- primed: set at the first accepted BFLY sample after reset; never cleared except by reset. out_valid = registered (in_valid && primed at or after that sample).
- out_sof: registered; asserted with the output produced by the cnt = D sample, i.e. the first BFLY sum of a frame that began with in_sof.
- in_sof mid-frame: cnt resynchronises; delay line and primed are not cleared; the first D outputs after it carry stale differences, which is accepted behaviour.
- Drain: the last frame's differences emerge only as D further samples are accepted; the upstream block supplies them (next frame or zero padding).

## Timing
- All outputs are registered; latency is 1 cycle from the accepted sample to its output.
- Reset: out_valid = 0, out_sof = 0, out_re = out_im = 0, cnt = 0, primed = 0, delay line all zero.
- in_valid low: outputs hold their values, out_valid = 0 the next cycle, cnt and delay line frozen.
- Back-to-back samples at one per cycle with no bubbles; throughput is 1 sample/clk.
- A single read and a single write of the same delay-line slot occur per accepted sample: read before write.

## Configuration
- SDF_BF_ROUND_EN defined: with SCALE = 1, output = (y + 1) >>> 1 (round half up).
- SDF_BF_ROUND_EN undefined: with SCALE = 1, output = y >>> 1 (truncate toward −∞).
- With SCALE = 0 the macro has no effect.

## Structure
- fft_pkg: bf_type_e enum (BF_I, BF_II), function sdf_delay(N_POINTS, STAGE, BF_TYPE) returning D, and the IW/OW width helpers; it is shared with the twiddle and top-level FFT blocks.
- Sub-module sdf_delay_line: circular buffer, parameters DEPTH, WIDTH; ports clk, rst, en, wr_data, rd_data; read pointer = write pointer; a D = 1 build collapses to a single register.
- sdf_bf_stage contains the counter, −j mux, add/sub, scaling and output registers.

## Test plan
- BFI, N=16, STAGE=1 (D=2), SCALE=0: re 1,2,3,4 with in_sof on the first sample, then 0,0 → outputs 4 (with out_sof), 6, then −2, −2; out_valid first high 1 cycle after the third sample.
- BFII, N=16, STAGE=1 (D=1): a0=(1,0), a1=(2,0), a2=(5,0), a3=(0,1) → outputs (3,0) with out_sof, (−1,0), (6,0).
- SCALE=1, BFI D=1: pair sums 3 and −3 → outputs 2 and −1 with SDF_BF_ROUND_EN defined; 1 and −2 without it.
- Extremes: DATA_WIDTH=16, both inputs −32768, SCALE=0 → sum −65536 at OW=17, no wrap; BFII −j applied to re = −32768 gives im = +32768 correctly.
- Stall: insert in_valid = 0 bubbles at random positions in the first scenario → identical output sequence, out_valid low one cycle after each bubble.
- Reset asserted mid-frame → all outputs 0 immediately; after release, a frame with in_sof reproduces the first scenario exactly; a mid-frame in_sof realigns out_sof to the cnt = D sample.
